// File: rtl/sha1_pad.sv
// sha1_pad -- SHA-1 message padder.
//
// Accepts a message as a stream of 32-bit big-endian words and emits
// 512-bit blocks padded with the standard 0x80 marker byte, zero fill
// and 64-bit big-endian bit length in the last two words of the final
// block. When the padding does not fit, an extra block is produced.
//
// Parameters:
//   N          data word width in bits (only 32 is supported)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   s_valid    message word valid
//   s_ready    message word accepted when s_valid && s_ready (FILL only)
//   s_data     message word, [31:24] is the first byte
//   s_last     final word of the message
//   s_bytes    valid bytes in the final word (0 means 4)
//   blk_valid  padded block available
//   blk_ready  downstream takes the block when blk_valid && blk_ready
//   blk_data   block, word 0 in [511:480], word 15 in [31:0]
//   blk_last   block is the final block of the message
//   blk_cnt    (only with SHA1_PAD_BLKCNT_EN) 0-based block index
//
// Configuration macro: SHA1_PAD_BLKCNT_EN adds the blk_cnt output.

module sha1_pad #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [N-1:0] s_data,
    input  logic         s_last,
    input  logic [1:0]   s_bytes,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last
`ifdef SHA1_PAD_BLKCNT_EN
    ,
    output logic [15:0]  blk_cnt
`endif
);

    typedef enum logic [2:0] {
        FILL = 3'd0,
        PADW = 3'd1,
        ZERO = 3'd2,
        LENH = 3'd3,
        LENL = 3'd4,
        EMIT = 3'd5
    } state_t;

    // Registered state
    state_t      state_q, state_d;
    state_t      pend_q, pend_d;      // state to resume after a non-final EMIT
    logic [3:0]  wcnt_q, wcnt_d;      // word index written this cycle
    logic [63:0] len_q, len_d;        // message length in bits
    logic        last_q, last_d;      // blk_last
    logic [31:0] buf_q [16];          // block buffer, one entry per word

    // Buffer write port
    logic        wr_en;
    logic [31:0] wr_data;

    logic        hs;

    // Final word: keep the valid bytes, place the 0x80 marker right after
    // them and clear whatever follows.
    function automatic logic [31:0] tail_word(input logic [31:0] d,
                                              input logic [1:0]  nb);
        logic [31:0] w;
        case (nb)
            2'd1:    w = {d[31:24], 8'h80, 16'h0000};
            2'd2:    w = {d[31:16], 8'h80, 8'h00};
            2'd3:    w = {d[31:8], 8'h80};
            default: w = d;
        endcase
        return w;
    endfunction

    // Next state after a padding word written at index w. Index 15 closes
    // the block; index 13 hands words 14/15 over to the length fields.
    function automatic state_t after_pad(input logic [3:0] w);
        state_t s;
        if (w == 4'd15) begin
            s = EMIT;
        end else if (w == 4'd13) begin
            s = LENH;
        end else begin
            s = ZERO;
        end
        return s;
    endfunction

    assign hs = (state_q == EMIT) && blk_ready;

    // Next-state and write-port logic
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        wcnt_d  = wcnt_q;
        len_d   = len_q;
        last_d  = last_q;
        wr_en   = 1'b0;
        wr_data = '0;

        case (state_q)
            FILL: begin
                if (s_valid) begin
                    wr_en  = 1'b1;
                    wcnt_d = wcnt_q + 4'd1;
                    if (!s_last) begin
                        wr_data = s_data;
                        len_d   = len_q + 64'd32;
                        if (wcnt_q == 4'd15) begin
                            state_d = EMIT;
                            pend_d  = FILL;
                        end
                    end else if (s_bytes == 2'd0) begin
                        wr_data = s_data;
                        len_d   = len_q + 64'd32;
                        if (wcnt_q == 4'd15) begin
                            state_d = EMIT;
                            pend_d  = PADW;
                        end else begin
                            state_d = PADW;
                        end
                    end else begin
                        wr_data = tail_word(s_data, s_bytes);
                        len_d   = len_q + {59'd0, s_bytes, 3'b000};
                        state_d = after_pad(wcnt_q);
                        pend_d  = ZERO;
                    end
                end
            end

            PADW: begin
                wr_en   = 1'b1;
                wr_data = 32'h8000_0000;
                wcnt_d  = wcnt_q + 4'd1;
                state_d = after_pad(wcnt_q);
                pend_d  = ZERO;
            end

            ZERO: begin
                wr_en   = 1'b1;
                wr_data = '0;
                wcnt_d  = wcnt_q + 4'd1;
                state_d = after_pad(wcnt_q);
                pend_d  = ZERO;
            end

            LENH: begin
                wr_en   = 1'b1;
                wr_data = len_q[63:32];
                wcnt_d  = wcnt_q + 4'd1;
                state_d = LENL;
            end

            LENL: begin
                wr_en   = 1'b1;
                wr_data = len_q[31:0];
                wcnt_d  = '0;
                state_d = EMIT;
                last_d  = 1'b1;
            end

            EMIT: begin
                if (blk_ready) begin
                    wcnt_d = '0;
                    last_d = 1'b0;
                    if (last_q) begin
                        state_d = FILL;
                        len_d   = '0;
                    end else begin
                        state_d = pend_q;
                    end
                end
            end

            default: begin
                state_d = FILL;
                wcnt_d  = '0;
                len_d   = '0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            pend_q  <= FILL;
            wcnt_q  <= '0;
            len_q   <= '0;
            last_q  <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            wcnt_q  <= wcnt_d;
            len_q   <= len_d;
            last_q  <= last_d;
            if (wr_en) begin
                buf_q[wcnt_q] <= wr_data;
            end
        end
    end

    // The buffer is never written in EMIT, so it can drive blk_data
    // directly and stays stable until the handshake.
    always_comb begin
        blk_data = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            blk_data[511 - 32*i -: 32] = buf_q[i];
        end
    end

    assign s_ready   = (state_q == FILL);
    assign blk_valid = (state_q == EMIT);
    assign blk_last  = last_q;

`ifdef SHA1_PAD_BLKCNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (hs) begin
            cnt_q <= last_q ? 16'd0 : cnt_q + 16'd1;
        end
    end

    assign blk_cnt = cnt_q;
`else
    logic unused_hs;
    assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_sha1_pad.sv
// tb_sha1_pad -- self-checking bench for sha1_pad.
//
// Messages are byte queues; the expected blocks are computed from the
// padding rule (append 0x80, zero to 56 mod 64, append 64-bit bit length)
// and compared against every block handed out by the DUT.

module tb_sha1_pad;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_data = '0;
    logic         s_last = 1'b0;
    logic [1:0]   s_bytes = '0;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic [511:0] blk_data;
    logic         blk_last;
`ifdef SHA1_PAD_BLKCNT_EN
    logic [15:0]  blk_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0]   msg[$];
    logic [511:0] exp_blk[$];
    logic [511:0] got_blk[$];

    int lens [14] = '{1, 3, 4, 52, 53, 54, 57, 59, 60, 63, 65, 119, 120, 128};

    always #5 clk = ~clk;

    sha1_pad #(.N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_bytes   (s_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last)
`ifdef SHA1_PAD_BLKCNT_EN
        ,
        .blk_cnt   (blk_cnt)
`endif
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wd(input logic [511:0] b, input int i);
        return b[511 - 32*i -: 32];
    endfunction

    // Reference model: padded byte stream cut into 64-byte blocks.
    function automatic void build_expected();
        logic [7:0]      p[$];
        logic [511:0]    v;
        longint unsigned bits;
        exp_blk.delete();
        p = msg;
        bits = longint'(msg.size()) * 8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8*i)));
        for (int b = 0; b < p.size() / 64; b++) begin
            v = '0;
            for (int j = 0; j < 64; j++) v[511 - 8*j -: 8] = p[64*b + j];
            exp_blk.push_back(v);
        end
    endfunction

    function automatic void random_msg(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom()));
    endfunction

    // Called and returns on a falling edge.
    task automatic send_word(input logic [31:0] w, input logic l, input logic [1:0] nb);
        int to;
        to = 0;
        s_valid = 1'b1;
        s_data  = w;
        s_last  = l;
        s_bytes = nb;
        while (!s_ready && to < 400) begin
            @(negedge clk);
            to++;
        end
        if (!s_ready) checkn("s_ready_wait", int'(s_ready), 1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic drive_msg(input int gap_pct);
        int nw;
        logic [31:0] w;
        nw = (msg.size() + 3) / 4;
        for (int k = 0; k < nw; k++) begin
            // bytes past the end of the message are garbage on purpose
            w = $urandom();
            for (int j = 0; j < 4; j++)
                if (4*k + j < msg.size()) w[31 - 8*j -: 8] = msg[4*k + j];
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                s_valid = 1'b0;
                s_data  = $urandom();
                s_last  = 1'($urandom());
                s_bytes = 2'($urandom());
                @(negedge clk);
            end
            if (k == nw - 1) send_word(w, 1'b1, 2'(msg.size()));
            else             send_word(w, 1'b0, 2'($urandom()));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic collect(input int nblk, input int ready_pct, input bit bp5);
        int got, cyc, hold;
        bit pv, hs_prev;
        logic [511:0] prev;
        got = 0; cyc = 0; hold = 0; pv = 0; hs_prev = 0; prev = '0;
        while (got < nblk && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (hs_prev) checkn("valid_drop", int'(blk_valid), 0);
            if (pv) begin
                checkn("hold_valid", int'(blk_valid), 1);
                check("hold_data", blk_data, prev);
            end
            hs_prev = 0;
            pv = 0;
            if (blk_valid && bp5 && got == 0 && hold < 5) begin
                blk_ready = 1'b0;
                hold++;
                checkn("bp_s_ready", int'(s_ready), 0);
            end else if (bp5) begin
                blk_ready = 1'b1;
            end else begin
                blk_ready = (int'($urandom_range(99)) < ready_pct);
            end
            if (blk_valid) begin
                if (blk_ready) begin
                    check("blk_data", blk_data, exp_blk[got]);
                    checkn("blk_last", int'(blk_last), (got == nblk - 1) ? 1 : 0);
`ifdef SHA1_PAD_BLKCNT_EN
                    checkn("blk_cnt", int'(blk_cnt), got);
`endif
                    if (bp5 && got == 0) checkn("bp_cycles", hold, 5);
                    got_blk.push_back(blk_data);
                    got++;
                    hs_prev = 1;
                end else begin
                    pv = 1;
                    prev = blk_data;
                end
            end
        end
        if (got < nblk) checkn("blk_timeout", got, nblk);
        @(negedge clk);
        blk_ready = 1'b0;
        if (hs_prev) checkn("valid_drop", int'(blk_valid), 0);
    endtask

    task automatic run_msg(input int gap, input int rdy, input bit bp5);
        build_expected();
        got_blk.delete();
        fork
            drive_msg(gap);
            collect(exp_blk.size(), rdy, bp5);
        join
        checkn("nblk", got_blk.size(), exp_blk.size());
    endtask

    function automatic void abc_msg();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endfunction

    initial begin
        logic [511:0] b0, b1;
        logic [511:0] mid;

        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkn("rst_s_ready", int'(s_ready), 1);
        checkn("rst_blk_valid", int'(blk_valid), 0);
        checkn("rst_blk_last", int'(blk_last), 0);
        check("rst_blk_data", blk_data, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // "abc" with 5 cycles of backpressure
        abc_msg();
        run_msg(0, 100, 1'b1);
        b0 = got_blk[0];
        checkn("abc_w0", int'(wd(b0, 0)), int'(32'h6162_6380));
        mid = '0;
        mid[447:0] = b0[479:32];
        check("abc_mid", mid, '0);
        checkn("abc_w15", int'(wd(b0, 15)), 32'h18);

        // 55 bytes: single block
        random_msg(55);
        run_msg(0, 100, 1'b0);
        b0 = got_blk[0];
        checkn("b55_w13_lo", int'(b0[511 - 32*13 - 24 -: 8]), 8'h80);
        checkn("b55_w14", int'(wd(b0, 14)), 0);
        checkn("b55_w15", int'(wd(b0, 15)), 32'h1B8);

        // 56 bytes: padding spills into a second block
        random_msg(56);
        run_msg(0, 100, 1'b0);
        b0 = got_blk[0];
        b1 = got_blk[1];
        checkn("b56_b0_w14", int'(wd(b0, 14)), int'(32'h8000_0000));
        checkn("b56_b0_w15", int'(wd(b0, 15)), 0);
        mid = b1;
        mid[31:0] = '0;
        check("b56_b1_zero", mid, '0);
        checkn("b56_b1_w15", int'(wd(b1, 15)), 32'h1C0);

        // 64 bytes: data block then a pure padding block
        random_msg(64);
        run_msg(10, 70, 1'b0);
        b1 = got_blk[1];
        checkn("b64_b1_w0", int'(wd(b1, 0)), int'(32'h8000_0000));
        checkn("b64_b1_w15", int'(wd(b1, 15)), 32'h200);

        // reset after 7 words of a message
        for (int k = 0; k < 7; k++) send_word($urandom(), 1'b0, 2'd0);
        rst_n = 1'b0;
        @(negedge clk);
        checkn("mid_rst_s_ready", int'(s_ready), 1);
        checkn("mid_rst_blk_valid", int'(blk_valid), 0);
        check("mid_rst_blk_data", blk_data, '0);
        rst_n = 1'b1;
        abc_msg();
        run_msg(0, 100, 1'b0);
        checkn("mid_rst_len", int'(wd(got_blk[0], 15)), 32'h18);

        // boundary lengths
        foreach (lens[i]) begin
            random_msg(lens[i]);
            run_msg(20, 60, 1'b0);
        end

        // random lengths, gaps and backpressure
        for (int t = 0; t < 20; t++) begin
            random_msg(int'($urandom_range(150, 1)));
            run_msg(int'($urandom_range(40)), int'($urandom_range(100, 20)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha1_pad.md
SHA1_PAD -- requirements
Module: sha1_pad

Interface
REQ-001 SHALL have parameter N, default 32, meaning data word width in bits; only 32 is supported.
REQ-002 SHALL have `clk` (input, 1): sole clock, rising edge.
REQ-003 SHALL have `rst_n` (input, 1): reset, synchronous, active-low.
REQ-004 SHALL have `s_valid` (input, 1): message word valid.
REQ-005 SHALL have `s_ready` (output, 1): message word accepted when `s_valid` and `s_ready` are both 1.
REQ-006 SHALL have `s_data` (input, N): message word, big-endian; `[31:24]` is the first byte.
REQ-007 SHALL have `s_last` (input, 1): final word of the message.
REQ-008 SHALL have `s_bytes` (input, 2): valid bytes in the `s_last` word, where 1-3 is literal and 0 means 4; ignored when `s_last` is 0.
REQ-009 SHALL have `blk_valid` (output, 1): padded 512-bit block available.
REQ-010 SHALL have `blk_ready` (input, 1): downstream takes the block when `blk_valid` and `blk_ready` are both 1.
REQ-011 SHALL have `blk_data` (output, 512): block; word 0 is in `[511:480]`, word 15 in `[31:0]`.
REQ-012 SHALL have `blk_last` (output, 1): block is the final block of the message.

Function
REQ-013 SHALL implement states FILL, PADW, ZERO, LENH, LENL, EMIT; each state except EMIT writes exactly one word into the block buffer per cycle at word index `wcnt` (0..15).
REQ-014 SHALL drive `s_ready` = 1 only in FILL; the module never stalls in FILL.
REQ-015 SHALL, on accepting a non-last word in FILL, store `s_data` and add 32 to the 64-bit bit-length counter `len`.
REQ-016 SHALL, on accepting an `s_last` word with `s_bytes` 1-3, store the valid bytes, put 0x80 in the next byte, zero the remaining bytes, add 8*`s_bytes` to `len`, and go to ZERO.
REQ-017 SHALL, on accepting an `s_last` word with `s_bytes` = 0, store the full word, add 32 to `len`, and go to PADW.
REQ-018 SHALL, in PADW, write 0x80000000 and then go to ZERO.
REQ-019 SHALL, in ZERO, write 0x00000000 until `wcnt` = 14, then go to LENH.
REQ-020 SHALL, if padding leaves `wcnt` > 14, fill zeros to `wcnt` = 15, emit the block with `blk_last` = 0, then build a new block of zeros through `wcnt` = 13 followed by LENH.
REQ-021 SHALL write `len[63:32]` in LENH and `len[31:0]` in LENL, then go to EMIT with `blk_last` = 1.
REQ-022 SHALL, when word 15 is written (any state), go to EMIT on the next cycle with `blk_valid` = 1, `blk_data` and `blk_last` held stable until the handshake.
REQ-023 SHALL, on handshake in EMIT, deassert `blk_valid` the next cycle and clear `wcnt` to 0.
REQ-024 SHALL resume the pending padding state after a handshake with `blk_last` = 0; after a handshake with `blk_last` = 1 it SHALL go to FILL and clear `len`.
REQ-025 SHALL ensure a handshake with `blk_ready` held high costs exactly one EMIT cycle.
REQ-026 SHALL wrap the `len` addition modulo 2^64; messages of zero bytes are not supported.
REQ-027 SHALL make `blk_data` unaffected by `s_valid` or `s_data` while not in FILL.

Reset
REQ-028 SHALL, on a clock edge with `rst_n` = 0, go to FILL and set `wcnt` = 0, `len` = 0, buffer = 0, `blk_valid` = 0, `blk_last` = 0, `blk_data` = 0.
REQ-029 SHALL drive `s_ready` = 1 from the first edge after reset.
REQ-030 SHALL let reset abort any message or block in progress, with no partial block ever emitted.

Configuration
REQ-031 SHALL, with macro `SHA1_PAD_BLKCNT_EN` defined, add output `blk_cnt` (16 bits): the 0-based index of the current block within its message, valid with `blk_valid`, cleared after a `blk_last` handshake and by reset, wrapping at 65536.
REQ-032 SHALL, without `SHA1_PAD_BLKCNT_EN`, omit the port and counter, with all other behaviour identical.

Verification
REQ-033 SHALL cover "abc": one word 0x61626300, `s_last` = 1, `s_bytes` = 3 -> one block: word 0 = 0x61626380, words 1-14 = 0, word 15 = 0x00000018, `blk_last` = 1.
REQ-034 SHALL cover 55 bytes: 13 full words plus a last word with `s_bytes` = 3 -> one block: word 13 low byte 0x80, word 14 = 0, word 15 = 0x000001B8.
REQ-035 SHALL cover 56 bytes: 14 full words, last with `s_bytes` = 0 -> block 0: word 14 = 0x80000000, word 15 = 0, `blk_last` = 0; block 1: zeros, word 15 = 0x000001C0, `blk_last` = 1.
REQ-036 SHALL cover 64 bytes: 16 words -> block 0 = data with `blk_last` = 0; block 1: word 0 = 0x80000000, word 15 = 0x00000200, `blk_last` = 1; `blk_cnt` = 0 then 1 when enabled.
REQ-037 SHALL cover backpressure: `blk_ready` held 0 for 5 cycles in EMIT -> `blk_valid` = 1 and `blk_data` unchanged for all 5 cycles, `s_ready` = 0, handshake on cycle 6.
REQ-038 SHALL cover reset mid-message: `rst_n` = 0 after 7 words -> next edge `s_ready` = 1 and `blk_valid` = 0; "abc" sent afterward yields length 0x18.
